minimac3_slotctl: RTL and testbench
===================================

MINIMAC3_SLOTCTL -- requirements
Module: minimac3_slotctl

Interface
REQ-001 SHALL have parameter csr_addr, default 4'h0, CSR bank select compared against csr_a[13:10].
REQ-002 SHALL have port sys_clk, input, 1, single clock for all logic.
REQ-003 SHALL have port sys_rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have ports csr_a input 14, csr_we input 1, csr_di input 32, csr_do output 32; CSR bus.
REQ-005 SHALL have ports irq_rx output 1, irq_tx output 1; interrupt lines.
REQ-006 SHALL have ports sys_rx_ready output 2, sys_rx_done input 2; per-RX-slot arm level / completion pulse.
REQ-007 SHALL have ports sys_rx_count_0 input 11, sys_rx_count_1 input 11; received byte counts per slot.
REQ-008 SHALL have ports sys_tx_start output 1, sys_tx_done input 1, sys_tx_count output 11; TX launch pulse / completion pulse / byte count.

Function
REQ-009 Bank selected SHALL mean csr_a[13:10] == csr_addr; register index SHALL be csr_a[2:0]; unselected bank ignores writes.
REQ-010 Register map SHALL be: 0 STATE0[1:0] rw, 1 COUNT0[10:0] ro, 2 STATE1[1:0] rw, 3 COUNT1[10:0] ro, 4 TXCOUNT[10:0] rw, 5-7 reserved (read 0, writes ignored).
REQ-011 csr_do SHALL be registered: value for csr_a sampled at edge N appears after edge N; csr_do SHALL be 0 when bank not selected; unused high bits read 0.
REQ-012 Each RX slot SHALL hold a 2-bit state: EMPTY=0, LOADED=1, PENDING=2; value 3 written SHALL be stored as EMPTY.
REQ-013 sys_rx_ready[i] SHALL equal (state_i == LOADED), combinationally from the state register.
REQ-014 CSR write to STATEi SHALL load csr_di[1:0] (per REQ-012) on the next edge.
REQ-015 sys_rx_done[i] high while state_i == LOADED SHALL set state_i to PENDING and capture sys_rx_count_i into COUNTi on the same edge.
REQ-016 sys_rx_done[i] while state_i != LOADED SHALL be ignored (state and COUNTi unchanged).
REQ-017 Simultaneous sys_rx_done[i] (state LOADED) and CSR write to STATEi SHALL resolve in favour of sys_rx_done (state PENDING, count captured, write dropped).
REQ-018 Slots 0 and 1 SHALL operate independently; simultaneous done on both SHALL update both.
REQ-019 irq_rx SHALL be registered, high in the cycle after either slot state is PENDING, low otherwise.
REQ-020 TX SHALL have states IDLE and BUSY; TXCOUNT reads the count register in both.
REQ-021 In IDLE, CSR write to TXCOUNT with csr_di[10:0] != 0 SHALL load the count register and enter BUSY; sys_tx_start SHALL pulse high for exactly one cycle, the cycle after the count register updates.
REQ-022 Write of TXCOUNT = 0 in IDLE SHALL be ignored; any TXCOUNT write in BUSY SHALL be ignored.
REQ-023 sys_tx_count SHALL equal the count register and SHALL remain stable throughout BUSY.
REQ-024 sys_tx_done high in BUSY SHALL clear the count register to 0, return to IDLE, and pulse irq_tx high for exactly one cycle on the following cycle.
REQ-025 sys_tx_done in IDLE, or in the same cycle as sys_tx_start, SHALL be ignored.

Reset
REQ-026 On sys_rst high at an edge: both slot states EMPTY, COUNT0/COUNT1 = 0, TX count 0, TX IDLE, sys_rx_ready = 2'b00, sys_tx_start = 0, irq_rx = 0, irq_tx = 0, csr_do = 0.
REQ-027 Reset mid-operation (slot LOADED or TX BUSY) SHALL abandon it; sys_rx_done/sys_tx_done arriving after reset SHALL be ignored per REQ-016/REQ-025.

Verification
REQ-028 Write STATE0=1; pulse sys_rx_done[0] with sys_rx_count_0=11'd64 -> sys_rx_ready[0] falls, STATE0 reads 2, COUNT0 reads 64, irq_rx high next cycle.
REQ-029 Write STATE1=1 and pulse sys_rx_done[1] (count 11'd1500) on the same edge as a CSR write STATE1=0 -> STATE1 reads 2, COUNT1 reads 1500.
REQ-030 Pulse sys_rx_done[0] with slot EMPTY, count 11'd99 -> STATE0 stays 0, COUNT0 unchanged, irq_rx stays 0.
REQ-031 Write TXCOUNT=11'd60 -> sys_tx_count=60 next cycle, one-cycle sys_tx_start the cycle after; write TXCOUNT=11'd100 while BUSY -> count stays 60; pulse sys_tx_done -> count 0, irq_tx one-cycle pulse.
REQ-032 Write TXCOUNT=0 in IDLE -> no sys_tx_start, count stays 0.
REQ-033 Assert sys_rst with slot 0 LOADED and TX BUSY -> all outputs at REQ-026 values; later sys_tx_done produces no irq_tx.

Source files
------------

// File: rtl/minimac3_slotctl_if.sv
// CSR bus plus RX-slot / TX handshake bundle for the minimac3 slot controller.
// "slave" is the controller side; "master" is the CSR host / MAC datapath side.
interface minimac3_slotctl_if;
   logic [13:0] csr_a;
   logic        csr_we;
   logic [31:0] csr_di;
   logic [31:0] csr_do;
   logic        irq_rx;
   logic        irq_tx;
   logic [1:0]  sys_rx_ready;
   logic [1:0]  sys_rx_done;
   logic [10:0] sys_rx_count_0;
   logic [10:0] sys_rx_count_1;
   logic        sys_tx_start;
   logic        sys_tx_done;
   logic [10:0] sys_tx_count;

   modport slave (
      input  csr_a, csr_we, csr_di, sys_rx_done, sys_rx_count_0, sys_rx_count_1, sys_tx_done,
      output csr_do, irq_rx, irq_tx, sys_rx_ready, sys_tx_start, sys_tx_count
   );

   modport master (
      output csr_a, csr_we, csr_di, sys_rx_done, sys_rx_count_0, sys_rx_count_1, sys_tx_done,
      input  csr_do, irq_rx, irq_tx, sys_rx_ready, sys_tx_start, sys_tx_count
   );
endinterface

// File: rtl/minimac3_slotctl.sv
// minimac3 slot controller: two RX buffer slots (EMPTY/LOADED/PENDING), one TX
// launch/complete FSM, and a small CSR bank with a registered read port.
module minimac3_slotctl #(
   parameter logic [3:0] csr_addr = 4'h0
) (
   input logic                 sys_clk,
   input logic                 sys_rst,
   minimac3_slotctl_if.slave   bus
);

   typedef enum logic [1:0] {
      SLOT_EMPTY   = 2'd0,
      SLOT_LOADED  = 2'd1,
      SLOT_PENDING = 2'd2
   } slot_state_t;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_BUSY = 1'b1
   } tx_state_t;

   localparam logic [2:0] IDX_TXCOUNT = 3'd4;

   logic        bank_sel;
   logic [2:0]  reg_idx;
   logic        csr_wr;
   logic [10:0] rx_count [2];
   slot_state_t slot_state [2];
   logic [10:0] slot_count [2];

   logic [31:0] csr_do_q, csr_do_d;
   logic        irq_rx_q, irq_rx_d;

   tx_state_t   tx_state_q;
   logic [10:0] tx_count_q;
   logic        tx_launch_q;
   logic        tx_start_q;
   logic        irq_tx_q;

   // Address bits between the bank select and the register index are don't-care,
   // and only the low data bits of any register are meaningful.
   logic unused_bits;
   assign unused_bits = ^{bus.csr_a[9:3], bus.csr_di[31:11]};

   assign bank_sel    = (bus.csr_a[13:10] == csr_addr);
   assign reg_idx     = bus.csr_a[2:0];
   assign csr_wr      = bank_sel && bus.csr_we;
   assign rx_count[0] = bus.sys_rx_count_0;
   assign rx_count[1] = bus.sys_rx_count_1;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot
         localparam logic [2:0] STATE_IDX = 3'(2 * gi);

         slot_state_t state_q, state_d;
         logic [10:0] count_q, count_d;

         // Completion on a LOADED slot wins over a simultaneous CSR state write.
         always_comb begin
            state_d = state_q;
            count_d = count_q;
            if (bus.sys_rx_done[gi] && (state_q == SLOT_LOADED)) begin
               state_d = SLOT_PENDING;
               count_d = rx_count[gi];
            end else if (csr_wr && (reg_idx == STATE_IDX)) begin
               case (bus.csr_di[1:0])
                  2'd1:    state_d = SLOT_LOADED;
                  2'd2:    state_d = SLOT_PENDING;
                  default: state_d = SLOT_EMPTY;
               endcase
            end
         end

         // Slot state and captured byte count.
         always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
               state_q <= SLOT_EMPTY;
               count_q <= '0;
            end else begin
               state_q <= state_d;
               count_q <= count_d;
            end
         end

         assign slot_state[gi]       = state_q;
         assign slot_count[gi]       = count_q;
         assign bus.sys_rx_ready[gi] = (state_q == SLOT_LOADED);
      end
   endgenerate

   // Read mux and RX interrupt source, both from the current register values.
   always_comb begin
      csr_do_d = '0;
      if (bank_sel) begin
         case (reg_idx)
            3'd0:        csr_do_d = {30'd0, slot_state[0]};
            3'd1:        csr_do_d = {21'd0, slot_count[0]};
            3'd2:        csr_do_d = {30'd0, slot_state[1]};
            3'd3:        csr_do_d = {21'd0, slot_count[1]};
            IDX_TXCOUNT: csr_do_d = {21'd0, tx_count_q};
            default:     csr_do_d = '0;
         endcase
      end
      irq_rx_d = (slot_state[0] == SLOT_PENDING) || (slot_state[1] == SLOT_PENDING);
   end

   // Registered CSR read data and RX interrupt.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         csr_do_q <= '0;
         irq_rx_q <= 1'b0;
      end else begin
         csr_do_q <= csr_do_d;
         irq_rx_q <= irq_rx_d;
      end
   end

   // TX FSM: a nonzero TXCOUNT write launches a frame; start pulses one cycle after
   // the count lands. Done during the start cycle is too early and is ignored; an
   // accepted done before start cancels the pending launch.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         tx_state_q  <= TX_IDLE;
         tx_count_q  <= '0;
         tx_launch_q <= 1'b0;
         tx_start_q  <= 1'b0;
         irq_tx_q    <= 1'b0;
      end else begin
         tx_launch_q <= 1'b0;
         tx_start_q  <= 1'b0;
         irq_tx_q    <= 1'b0;
         case (tx_state_q)
            TX_IDLE: begin
               if (csr_wr && (reg_idx == IDX_TXCOUNT) && (bus.csr_di[10:0] != 11'd0)) begin
                  tx_count_q  <= bus.csr_di[10:0];
                  tx_launch_q <= 1'b1;
                  tx_state_q  <= TX_BUSY;
               end
            end
            TX_BUSY: begin
               if (bus.sys_tx_done && !tx_start_q) begin
                  tx_count_q <= '0;
                  irq_tx_q   <= 1'b1;
                  tx_state_q <= TX_IDLE;
               end else begin
                  tx_start_q <= tx_launch_q;
               end
            end
            default: tx_state_q <= TX_IDLE;
         endcase
      end
   end

   assign bus.csr_do       = csr_do_q;
   assign bus.irq_rx       = irq_rx_q;
   assign bus.irq_tx       = irq_tx_q;
   assign bus.sys_tx_start = tx_start_q;
   assign bus.sys_tx_count = tx_count_q;

endmodule

// File: tb/tb_minimac3_slotctl.sv
// Bench for minimac3_slotctl: directed vector table, a reset-abandon sequence, and
// randomized traffic scored against a cycle-scheduled behavioural model.
module tb_minimac3_slotctl;

   localparam logic [3:0] BANK = 4'h5;

   logic sys_clk = 1'b0;
   logic sys_rst;

   minimac3_slotctl_if ifc ();

   minimac3_slotctl #(.csr_addr(BANK)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (ifc)
   );

   always #5 sys_clk = ~sys_clk;

   int checks   = 0;
   int failures = 0;
   int edges    = 0;

   // Behavioural model: register file contents plus the edge number at which the
   // TX start pulse is due.
   logic [1:0]  m_state [2];
   logic [10:0] m_count [2];
   bit          m_tx_busy;
   logic [10:0] m_tx_count;
   int          m_start_edge;
   logic [31:0] m_do;
   bit          m_irq_rx;
   bit          m_irq_tx;

   typedef struct {
      logic        rst;
      logic        we;
      logic [13:0] a;
      logic [31:0] di;
      logic [1:0]  rxd;
      logic [10:0] c0;
      logic [10:0] c1;
      logic        txd;
      logic [31:0] e_do;
      logic [1:0]  e_rdy;
      logic        e_irx;
      logic        e_itx;
      logic        e_st;
      logic [10:0] e_tc;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [13:0] A(input logic [2:0] idx);
      return {BANK, 7'd0, idx};
   endfunction

   function automatic void add(input logic rst, input logic we, input logic [13:0] a,
                               input logic [31:0] di, input logic [1:0] rxd,
                               input logic [10:0] c0, input logic [10:0] c1, input logic txd,
                               input logic [31:0] e_do, input logic [1:0] e_rdy,
                               input logic e_irx, input logic e_itx, input logic e_st,
                               input logic [10:0] e_tc);
      vec_t v;
      v.rst = rst; v.we = we; v.a = a; v.di = di; v.rxd = rxd; v.c0 = c0; v.c1 = c1;
      v.txd = txd; v.e_do = e_do; v.e_rdy = e_rdy; v.e_irx = e_irx; v.e_itx = e_itx;
      v.e_st = e_st; v.e_tc = e_tc;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, edges, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic we, input logic [13:0] a,
                        input logic [31:0] di, input logic [1:0] rxd,
                        input logic [10:0] c0, input logic [10:0] c1, input logic txd);
      sys_rst            = rst;
      ifc.csr_we         = we;
      ifc.csr_a          = a;
      ifc.csr_di         = di;
      ifc.sys_rx_done    = rxd;
      ifc.sys_rx_count_0 = c0;
      ifc.sys_rx_count_1 = c1;
      ifc.sys_tx_done    = txd;
   endtask

   function automatic logic [31:0] m_read(input logic [2:0] idx);
      case (idx)
         3'd0:    return {30'd0, m_state[0]};
         3'd1:    return {21'd0, m_count[0]};
         3'd2:    return {30'd0, m_state[1]};
         3'd3:    return {21'd0, m_count[1]};
         3'd4:    return {21'd0, m_tx_count};
         default: return 32'd0;
      endcase
   endfunction

   // Advance the model across one clock edge using the inputs now being driven.
   task automatic model_edge();
      bit          sel;
      bit          wr;
      bit          start_now;
      logic [2:0]  idx;
      logic [10:0] rc;
      sel = (ifc.csr_a[13:10] == BANK);
      idx = ifc.csr_a[2:0];
      wr  = sel && ifc.csr_we;
      if (sys_rst) begin
         m_state[0] = 2'd0; m_state[1] = 2'd0;
         m_count[0] = 11'd0; m_count[1] = 11'd0;
         m_tx_busy = 1'b0; m_tx_count = 11'd0; m_start_edge = -10;
         m_do = 32'd0; m_irq_rx = 1'b0; m_irq_tx = 1'b0;
      end else begin
         m_do      = sel ? m_read(idx) : 32'd0;
         m_irq_rx  = (m_state[0] == 2'd2) || (m_state[1] == 2'd2);
         start_now = m_tx_busy && (edges == m_start_edge);
         m_irq_tx  = 1'b0;
         if (m_tx_busy) begin
            if (ifc.sys_tx_done && !start_now) begin
               m_tx_busy  = 1'b0;
               m_tx_count = 11'd0;
               m_irq_tx   = 1'b1;
            end
         end else if (wr && idx == 3'd4 && ifc.csr_di[10:0] != 11'd0) begin
            m_tx_busy    = 1'b1;
            m_tx_count   = ifc.csr_di[10:0];
            m_start_edge = edges + 2;
         end
         for (int i = 0; i < 2; i++) begin
            rc = (i == 0) ? ifc.sys_rx_count_0 : ifc.sys_rx_count_1;
            if (ifc.sys_rx_done[i] && m_state[i] == 2'd1) begin
               m_state[i] = 2'd2;
               m_count[i] = rc;
            end else if (wr && idx == 3'(2 * i)) begin
               m_state[i] = (ifc.csr_di[1:0] == 2'd3) ? 2'd0 : ifc.csr_di[1:0];
            end
         end
      end
      edges++;
   endtask

   task automatic tick();
      model_edge();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic compare_model(input string tag);
      logic [1:0] rdy;
      rdy = {m_state[1] == 2'd1, m_state[0] == 2'd1};
      check({tag, ".csr_do"},    ifc.csr_do, m_do);
      check({tag, ".rx_ready"},  {30'd0, ifc.sys_rx_ready}, {30'd0, rdy});
      check({tag, ".irq_rx"},    {31'd0, ifc.irq_rx}, {31'd0, m_irq_rx});
      check({tag, ".irq_tx"},    {31'd0, ifc.irq_tx}, {31'd0, m_irq_tx});
      check({tag, ".tx_start"},  {31'd0, ifc.sys_tx_start},
            {31'd0, m_tx_busy && (edges == m_start_edge)});
      check({tag, ".tx_count"},  {21'd0, ifc.sys_tx_count}, {21'd0, m_tx_count});
   endtask

   initial begin
      //   rst we a        di            rxd    c0      c1       txd  do     rdy    irx itx st  tc
      add(1, 0, A(0), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd0,    2'b00, 0, 0, 0, 11'd0);
      add(0, 1, A(0), 32'd1,        2'b00, 11'd0,  11'd0,    0, 32'd0,    2'b01, 0, 0, 0, 11'd0);
      add(0, 0, A(0), 32'd0,        2'b01, 11'd64, 11'd0,    0, 32'd1,    2'b00, 0, 0, 0, 11'd0);
      add(0, 0, A(0), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd2,    2'b00, 1, 0, 0, 11'd0);
      add(0, 0, A(1), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd64,   2'b00, 1, 0, 0, 11'd0);
      add(0, 1, A(2), 32'd1,        2'b00, 11'd0,  11'd0,    0, 32'd0,    2'b10, 1, 0, 0, 11'd0);
      add(0, 1, A(2), 32'd0,        2'b10, 11'd0,  11'd1500, 0, 32'd1,    2'b00, 1, 0, 0, 11'd0);
      add(0, 0, A(2), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd2,    2'b00, 1, 0, 0, 11'd0);
      add(0, 0, A(3), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd1500, 2'b00, 1, 0, 0, 11'd0);
      add(0, 1, A(0), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd2,    2'b00, 1, 0, 0, 11'd0);
      add(0, 1, A(2), 32'd3,        2'b00, 11'd0,  11'd0,    0, 32'd2,    2'b00, 1, 0, 0, 11'd0);
      add(0, 0, A(2), 32'd0,        2'b01, 11'd99, 11'd0,    0, 32'd0,    2'b00, 0, 0, 0, 11'd0);
      add(0, 0, A(1), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd64,   2'b00, 0, 0, 0, 11'd0);
      add(0, 0, A(0), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd0,    2'b00, 0, 0, 0, 11'd0);
      add(0, 1, 14'h0000, 32'd1,    2'b00, 11'd0,  11'd0,    0, 32'd0,    2'b00, 0, 0, 0, 11'd0);
      add(0, 0, A(0), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd0,    2'b00, 0, 0, 0, 11'd0);
      add(0, 1, A(4), 32'd60,       2'b00, 11'd0,  11'd0,    0, 32'd0,    2'b00, 0, 0, 0, 11'd60);
      add(0, 0, A(4), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd60,   2'b00, 0, 0, 1, 11'd60);
      add(0, 1, A(4), 32'd100,      2'b00, 11'd0,  11'd0,    0, 32'd60,   2'b00, 0, 0, 0, 11'd60);
      add(0, 0, A(4), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd60,   2'b00, 0, 0, 0, 11'd60);
      add(0, 0, A(4), 32'd0,        2'b00, 11'd0,  11'd0,    1, 32'd60,   2'b00, 0, 1, 0, 11'd0);
      add(0, 0, A(4), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd0,    2'b00, 0, 0, 0, 11'd0);
      add(0, 1, A(4), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd0,    2'b00, 0, 0, 0, 11'd0);
      add(0, 0, A(4), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd0,    2'b00, 0, 0, 0, 11'd0);
      add(0, 0, A(4), 32'd0,        2'b00, 11'd0,  11'd0,    1, 32'd0,    2'b00, 0, 0, 0, 11'd0);
      add(0, 0, A(4), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd0,    2'b00, 0, 0, 0, 11'd0);
      add(0, 1, A(4), 32'd5,        2'b00, 11'd0,  11'd0,    0, 32'd0,    2'b00, 0, 0, 0, 11'd5);
      add(0, 0, A(4), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd5,    2'b00, 0, 0, 1, 11'd5);
      add(0, 0, A(4), 32'd0,        2'b00, 11'd0,  11'd0,    1, 32'd5,    2'b00, 0, 0, 0, 11'd5);
      add(0, 0, A(4), 32'd0,        2'b00, 11'd0,  11'd0,    1, 32'd5,    2'b00, 0, 1, 0, 11'd0);
      add(0, 0, A(4), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd0,    2'b00, 0, 0, 0, 11'd0);
      add(0, 1, A(5), 32'hFFFFFFFF, 2'b00, 11'd0,  11'd0,    0, 32'd0,    2'b00, 0, 0, 0, 11'd0);
      add(0, 0, A(5), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd0,    2'b00, 0, 0, 0, 11'd0);
      add(0, 0, A(7), 32'd0,        2'b00, 11'd0,  11'd0,    0, 32'd0,    2'b00, 0, 0, 0, 11'd0);

      drive(1, 0, A(0), 32'd0, 2'b00, 11'd0, 11'd0, 0);
      tick();
      tick();

      // Directed table.
      foreach (vecs[n]) begin
         drive(vecs[n].rst, vecs[n].we, vecs[n].a, vecs[n].di, vecs[n].rxd,
               vecs[n].c0, vecs[n].c1, vecs[n].txd);
         tick();
         $display("vec %0d a=%h we=%0d di=%h rxd=%b txd=%0d -> do=%0h rdy=%b irx=%0d itx=%0d st=%0d tc=%0d",
                  n, vecs[n].a, vecs[n].we, vecs[n].di, vecs[n].rxd, vecs[n].txd, ifc.csr_do,
                  ifc.sys_rx_ready, ifc.irq_rx, ifc.irq_tx, ifc.sys_tx_start, ifc.sys_tx_count);
         check($sformatf("vec%0d.csr_do", n),   ifc.csr_do, vecs[n].e_do);
         check($sformatf("vec%0d.rx_ready", n), {30'd0, ifc.sys_rx_ready}, {30'd0, vecs[n].e_rdy});
         check($sformatf("vec%0d.irq_rx", n),   {31'd0, ifc.irq_rx}, {31'd0, vecs[n].e_irx});
         check($sformatf("vec%0d.irq_tx", n),   {31'd0, ifc.irq_tx}, {31'd0, vecs[n].e_itx});
         check($sformatf("vec%0d.tx_start", n), {31'd0, ifc.sys_tx_start}, {31'd0, vecs[n].e_st});
         check($sformatf("vec%0d.tx_count", n), {21'd0, ifc.sys_tx_count}, {21'd0, vecs[n].e_tc});
      end

      // Reset while slot 0 is LOADED and TX is mid-launch; late completions are dropped.
      drive(0, 1, A(0), 32'd1, 2'b00, 11'd0, 11'd0, 0);
      tick();
      drive(0, 1, A(4), 32'd60, 2'b00, 11'd0, 11'd0, 0);
      tick();
      drive(0, 0, A(0), 32'd0, 2'b00, 11'd0, 11'd0, 0);
      tick();
      check("pre_rst.rx_ready", {30'd0, ifc.sys_rx_ready}, 32'd1);
      check("pre_rst.tx_start", {31'd0, ifc.sys_tx_start}, 32'd1);
      drive(1, 0, A(0), 32'd0, 2'b00, 11'd0, 11'd0, 0);
      tick();
      $display("reset-abandon: rdy=%b st=%0d tc=%0d do=%0h", ifc.sys_rx_ready,
               ifc.sys_tx_start, ifc.sys_tx_count, ifc.csr_do);
      check("rst.rx_ready", {30'd0, ifc.sys_rx_ready}, 32'd0);
      check("rst.tx_start", {31'd0, ifc.sys_tx_start}, 32'd0);
      check("rst.tx_count", {21'd0, ifc.sys_tx_count}, 32'd0);
      check("rst.irq_rx",   {31'd0, ifc.irq_rx}, 32'd0);
      check("rst.irq_tx",   {31'd0, ifc.irq_tx}, 32'd0);
      check("rst.csr_do",   ifc.csr_do, 32'd0);
      drive(0, 0, A(0), 32'd0, 2'b01, 11'd77, 11'd0, 1);
      tick();
      drive(0, 0, A(1), 32'd0, 2'b00, 11'd0, 11'd0, 0);
      tick();
      $display("post-reset done pulses: irq_tx=%0d do=%0h", ifc.irq_tx, ifc.csr_do);
      check("post_rst.irq_tx", {31'd0, ifc.irq_tx}, 32'd0);
      check("post_rst.count0", ifc.csr_do, 32'd0);
      drive(0, 0, A(0), 32'd0, 2'b00, 11'd0, 11'd0, 0);
      tick();
      check("post_rst.state0", ifc.csr_do, 32'd0);
      check("post_rst.irq_rx", {31'd0, ifc.irq_rx}, 32'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         logic [31:0] di;
         logic [3:0]  bank;
         di   = $urandom;
         if ($urandom_range(0, 3) == 0) di = di & 32'h3;
         bank = ($urandom_range(0, 7) == 0) ? 4'h3 : BANK;
         drive($urandom_range(0, 99) == 0,
               $urandom_range(0, 2) == 0,
               {bank, 7'($urandom), 3'($urandom)},
               di,
               {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0},
               11'($urandom), 11'($urandom),
               $urandom_range(0, 4) == 0);
         tick();
         $display("rand %0d rst=%0d we=%0d a=%h di=%h rxd=%b txd=%0d -> do=%0h rdy=%b irx=%0d itx=%0d st=%0d tc=%0d",
                  n, sys_rst, ifc.csr_we, ifc.csr_a, ifc.csr_di, ifc.sys_rx_done, ifc.sys_tx_done,
                  ifc.csr_do, ifc.sys_rx_ready, ifc.irq_rx, ifc.irq_tx, ifc.sys_tx_start,
                  ifc.sys_tx_count);
         compare_model($sformatf("rand%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
